input_debounce_conditioner: RTL and testbench
=============================================

// Module: input_debounce_conditioner
// PURPOSE
//  Conditions the 8 raw request lines (switches/buttons on ui) before the 8:3 priority
//  encoder and 7-segment decoder stage. Per bit: synchronise, debounce, detect rising edges.
//  Optionally holds (sticky) requests until cleared, so a short button press stays on the display.
//  Sits between the ui pins and the priority encoder input; dout drives the encoder directly.
// PARAMETERS
//  WIDTH            8   number of request lines
//  SYNC_STAGES      2   synchroniser flops per bit (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable synced samples needed to accept a change (>=2)
// PORTS
//  clk         in   1      single system clock
//  rst_n       in   1      reset, asynchronous assert, active-low
//  ena         in   1      enable; low freezes debounce counters, dout, rise, latch
//  din         in   WIDTH  raw asynchronous request inputs
//  clr         in   1      synchronous clear of sticky latch (ignored without STICKY_LATCH_EN)
//  dout        out  WIDTH  conditioned requests to priority encoder
//  rise        out  WIDTH  one-cycle pulse per bit on accepted 0->1 transition
//  any_active  out  1      |dout
// BEHAVIOUR
//  - Reset (rst_n low, async): sync chains, counters, debounced state, latch, dout, rise,
//    any_active all 0. Release takes effect on next clk edge.
//  - Sync: SYNC_STAGES-deep flop chain per bit, always running (ignores ena).
//  - Debounce per bit, counter width $clog2(DEBOUNCE_CYCLES):
//    synced==deb -> cnt<=0; synced!=deb and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1;
//    synced!=deb and cnt==DEBOUNCE_CYCLES-1 -> deb<=synced, cnt<=0. Counter never wraps.
//  - Latency: clean step on din, edge 1 = first edge sampling new level -> deb changes on
//    edge SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults).
//  - Glitch: any synced sample equal to deb restarts count; pulses shorter than
//    DEBOUNCE_CYCLES synced cycles never reach dout.
//  - rise[i] high exactly one cycle, registered, the cycle after deb[i] goes 0->1.
//    No pulse on 1->0.
//  - ena low: cnt, deb, latch hold; rise forced 0. Resuming continues from held cnt.
//  - Bits are independent; simultaneous changes on several bits each obey the rules above.
//  - any_active combinational OR of dout.
// CONFIGURATION
//  STICKY_LATCH_EN defined: latch[i] <= (latch[i] & ~clr) | rise_event[i];
//    set wins over simultaneous clr; dout = latch. Release of a button does not clear dout;
//    only clr (with ena high) or reset does.
//  STICKY_LATCH_EN undefined: no latch flops; dout = deb; clr port present but unused.
// STRUCTURE
//  - Package pe_cond_pkg: WIDTH default, SYNC_STAGES default, DEBOUNCE_CYCLES default,
//    CNT_W = $clog2(DEBOUNCE_CYCLES) localparam. Shared with encoder/decoder top.
//  - Sub-module debounce_bit (sync chain + counter + deb flop + rise pulse), generated WIDTH
//    times; sticky latch, any_active in this module.
// TESTING
//  1 Reset: rst_n=0 mid-count with din=8'hFF -> all outputs 0 immediately, cnt restarts
//    after release.
//  2 Clean press: din 8'h00->8'h10 held -> dout=8'h10 on edge 18, rise=8'h10 for one cycle
//    following, any_active=1.
//  3 Glitch: din[3] high 10 cycles then low -> dout stays 8'h00, rise never asserted.
//  4 Bounce: din[7] toggles every 5 cycles x4 then steady high -> dout[7] rises 18 edges
//    after last toggle.
//  5 ena: drop ena at cnt=8 for 20 cycles, din held -> dout frozen, accepts change 8 enabled
//    cycles after ena returns.
//  6 STICKY_LATCH_EN: press/release bit2 -> dout[2] stays 1; clr -> 0 next edge; clr same
//    cycle as rise on bit5 -> dout[5]=1.

Source files
------------

// File: rtl/pe_cond_pkg.sv
// Shared defaults for the request-conditioning stage ahead of the priority encoder.
// Latency: n/a (constants only). Backpressure: n/a.
package pe_cond_pkg;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int CNT_W               = $clog2(DEF_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounce_bit.sv
// One request line: synchroniser chain, stability counter, debounced level, rise pulse.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from a clean step. No backpressure; ena low freezes.
module debounce_bit
  import pe_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic deb,
  output logic rise,
  output logic rise_evt
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic                   differ;
  logic                   accept;

  // The synchroniser free-runs so a resumed enable sees the current pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign differ   = synced ^ deb;
  assign accept   = ena & differ & (cnt == CNT_MAX);
  assign rise_evt = accept & synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      deb  <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= rise_evt;
      if (ena) begin
        if (!differ) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          deb <= synced;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_debounce_conditioner.sv
// Conditions WIDTH raw request lines for the priority encoder; STICKY_LATCH_EN holds presses until clr.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges to dout. No backpressure; ena low freezes dout/rise/latch.
module input_debounce_conditioner
  import pe_cond_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic             any_active
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] rise_evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .din     (din[i]),
      .deb     (deb[i]),
      .rise    (rise[i]),
      .rise_evt(rise_evt[i])
    );
  end

`ifdef STICKY_LATCH_EN
  logic [WIDTH-1:0] latch_q;
  logic             unused_deb;

  // A new press sets its bit even if clr arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= '0;
    end else if (ena) begin
      latch_q <= (latch_q & ~{WIDTH{clr}}) | rise_evt;
    end
  end

  assign dout       = latch_q;
  assign unused_deb = ^deb;
`else
  logic unused_sticky;

  assign dout          = deb;
  assign unused_sticky = ^{clr, rise_evt};
`endif

  assign any_active = |dout;

endmodule

// File: tb/tb_input_debounce_conditioner.sv
// Bench for input_debounce_conditioner: directed literal cases plus randomised traffic vs a run-length model.
module tb_input_debounce_conditioner;
  import pe_cond_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int S = DEF_SYNC_STAGES;
  localparam int D = DEF_DEBOUNCE_CYCLES;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] din;
  logic         clr;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic         any_active;

  int n_checks = 0;
  int n_fail   = 0;

  input_debounce_conditioner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .clr       (clr),
    .dout      (dout),
    .rise      (rise),
    .any_active(any_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin history delayed S samples; a level is accepted once D consecutive
  // enabled samples disagree with the current debounced level.
  logic [W-1:0] hist [S];
  int           run  [W];
  logic [W-1:0] m_deb, m_latch, m_rise, m_synced, m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) hist[k] = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
      m_deb   = '0;
      m_latch = '0;
      m_rise  = '0;
    end else begin
      m_synced = hist[S-1];
      m_rise   = '0;
      if (ena) begin
        for (int i = 0; i < W; i++) begin
          if (m_synced[i] == m_deb[i]) begin
            run[i] = 0;
          end else begin
            run[i] = run[i] + 1;
            if (run[i] == D) begin
              m_deb[i] = m_synced[i];
              run[i]   = 0;
              if (m_synced[i]) m_rise[i] = 1'b1;
            end
          end
        end
        if (clr) m_latch = '0;
        m_latch = m_latch | m_rise;
      end
      for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
    end
  end

`ifdef STICKY_LATCH_EN
  assign m_dout = m_latch;
`else
  assign m_dout = m_deb;
`endif

  always @(negedge clk) begin
    check("model_dout", {24'h0, dout}, {24'h0, m_dout});
    check("model_rise", {24'h0, rise}, {24'h0, m_rise});
    check("model_any_active", {31'h0, any_active}, {31'h0, |m_dout});
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    din   = '0;
    clr   = 1'b0;
    ena   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] seen;
  logic [W-1:0] lvl;
  int           rem [W];

  initial begin
    din   = '0;
    ena   = 1'b1;
    clr   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_edges(3);
    check("reset_dout", {24'h0, dout}, 32'h0);
    check("reset_rise", {24'h0, rise}, 32'h0);
    check("reset_any", {31'h0, any_active}, 32'h0);

    // Reset mid-count: accepted FF, start moving to 00, then reset asynchronously.
    rst_n = 1'b1;
    din   = 8'hFF;
    wait_edges(17);
    check("t1_before_accept", {24'h0, dout}, 32'h0);
    wait_edges(1);
    check("t1_accept_dout", {24'h0, dout}, 32'hFF);
    check("t1_accept_rise", {24'h0, rise}, 32'hFF);
    din = 8'h00;
    wait_edges(8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_dout", {24'h0, dout}, 32'h0);
    check("t1_async_rise", {24'h0, rise}, 32'h0);
    check("t1_async_any", {31'h0, any_active}, 32'h0);
    @(negedge clk);
    din   = 8'hFF;
    rst_n = 1'b1;
    wait_edges(17);
    check("t1_restart_17", {24'h0, dout}, 32'h0);
    wait_edges(1);
    check("t1_restart_18", {24'h0, dout}, 32'hFF);

    // Clean press on bit 4.
    do_reset();
    din = 8'h10;
    wait_edges(17);
    check("t2_edge17_dout", {24'h0, dout}, 32'h0);
    wait_edges(1);
    check("t2_edge18_dout", {24'h0, dout}, 32'h10);
    check("t2_edge18_rise", {24'h0, rise}, 32'h10);
    check("t2_edge18_any", {31'h0, any_active}, 32'h1);
    wait_edges(1);
    check("t2_edge19_rise", {24'h0, rise}, 32'h0);
    check("t2_edge19_dout", {24'h0, dout}, 32'h10);

    // Short pulse on bit 3 must be rejected.
    do_reset();
    seen = '0;
    din  = 8'h08;
    repeat (10) begin
      @(negedge clk);
      seen = seen | dout | rise;
    end
    din = 8'h00;
    repeat (30) begin
      @(negedge clk);
      seen = seen | dout | rise;
    end
    check("t3_glitch_seen", {24'h0, seen}, 32'h0);

    // Bouncing bit 7, then steady high.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      din = (t % 2 == 0) ? 8'h80 : 8'h00;
      wait_edges(5);
    end
    din = 8'h80;
    wait_edges(17);
    check("t4_bounce_17", {31'h0, dout[7]}, 32'h0);
    wait_edges(1);
    check("t4_bounce_18", {31'h0, dout[7]}, 32'h1);

    // Enable drop at count 8 freezes the count.
    do_reset();
    din = 8'h01;
    wait_edges(10);
    ena = 1'b0;
    wait_edges(20);
    check("t5_frozen_dout", {24'h0, dout}, 32'h0);
    ena = 1'b1;
    wait_edges(7);
    check("t5_resume_7", {24'h0, dout}, 32'h0);
    wait_edges(1);
    check("t5_resume_8", {24'h0, dout}, 32'h01);

`ifdef STICKY_LATCH_EN
    do_reset();
    din = 8'h04;
    wait_edges(18);
    check("t6_press", {24'h0, dout}, 32'h04);
    din = 8'h00;
    wait_edges(25);
    check("t6_hold", {24'h0, dout}, 32'h04);
    clr = 1'b1;
    wait_edges(1);
    clr = 1'b0;
    check("t6_clear", {24'h0, dout}, 32'h0);
    din = 8'h20;
    wait_edges(17);
    clr = 1'b1;
    wait_edges(1);
    clr = 1'b0;
    check("t6_set_wins", {24'h0, dout}, 32'h20);
`endif

    // Randomised traffic: random-length level runs per bit, sparse ena drops, clr, resets.
    do_reset();
    lvl = '0;
    for (int i = 0; i < W; i++) rem[i] = 0;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          rem[i] = int'($urandom_range(1, 40));
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
      din = lvl;
      ena = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
